// File: rtl/pipeline_exec_ctrl_if.sv
// Host/pipeline signal bundle for the execution controller.
// The controller attaches through the slave modport; the host/testbench side uses master.
interface pipeline_exec_ctrl_if #(
  parameter int CYCLE_W = 32
);
  logic [7:0]         cmd_data;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        pc_instr_in;
  logic               pc_enable_out;
  logic               pc_reset_out;
  logic [CYCLE_W-1:0] cycle_count;
  logic [7:0]         status_data;
  logic               status_valid;
  logic               status_ready;
  logic [2:0]         state_out;

  modport slave (
    input  cmd_data, cmd_valid, pc_instr_in, status_ready,
    output cmd_ready, pc_enable_out, pc_reset_out, cycle_count,
           status_data, status_valid, state_out
  );

  modport master (
    output cmd_data, cmd_valid, pc_instr_in, status_ready,
    input  cmd_ready, pc_enable_out, pc_reset_out, cycle_count,
           status_data, status_valid, state_out
  );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Debug-host execution controller for the MIPS pipeline: reset / step / run / pause,
// HALT detection with a fixed drain, enabled-cycle counter and one status byte per command.
module pipeline_exec_ctrl #(
  parameter int          CYCLE_W      = 32,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_exec_ctrl_if.slave  bus
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  localparam logic [7:0] ST_RESET  = 8'h00;
  localparam logic [7:0] ST_STEP   = 8'h01;
  localparam logic [7:0] ST_HALT   = 8'h02;
  localparam logic [7:0] ST_PAUSE  = 8'h03;
  localparam logic [7:0] ST_HALTED = 8'hE1;
  localparam logic [7:0] ST_BADCMD = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRST   = 3'd1,
    S_STEP   = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_REPORT = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  state_e               ret_q, ret_d;
  logic [7:0]           status_q, status_d;
  logic                 prst_cmd_q, prst_cmd_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [CYCLE_W-1:0]   count_q, count_d;

  logic enable_s;
  logic ready_s;
  logic fire_s;
  logic halt_s;
  logic unused_instr_s;

  assign enable_s = (state_q == S_STEP) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ready_s  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
  assign fire_s   = bus.cmd_valid && ready_s;
  // HALT is ignored while draining so the drain length stays fixed
  assign halt_s   = enable_s && (state_q != S_DRAIN) &&
                    (bus.pc_instr_in[31:26] == HALT_OPCODE);
  assign unused_instr_s = ^bus.pc_instr_in[25:0];

  // Next-state, status and drain-counter decode
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    status_d   = status_q;
    prst_cmd_d = prst_cmd_q;
    drain_d    = drain_q;
    case (state_q)
      S_IDLE: begin
        if (fire_s) begin
          case (bus.cmd_data)
            CMD_RESET: begin state_d = S_PRST; prst_cmd_d = 1'b1; end
            CMD_STEP:  state_d = S_STEP;
            CMD_CONT:  state_d = S_RUN;
            default:   begin state_d = S_REPORT; status_d = ST_BADCMD; ret_d = S_IDLE; end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRST: begin
        prst_cmd_d = 1'b0;
        if (prst_cmd_q) begin
          state_d  = S_REPORT;
          status_d = ST_RESET;
          ret_d    = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (halt_s) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else begin
          state_d  = S_REPORT;
          status_d = ST_STEP;
          ret_d    = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_s) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else if (fire_s && (bus.cmd_data == CMD_PAUSE)) begin
          state_d  = S_REPORT;
          status_d = ST_PAUSE;
          ret_d    = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q <= DRAIN_W'(1)) begin
          state_d  = S_REPORT;
          status_d = ST_HALT;
          ret_d    = S_DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_REPORT: begin
        if (bus.status_ready) begin
          state_d = ret_q;
        end else begin
          state_d = S_REPORT;
        end
      end
      S_DONE: begin
        if (fire_s) begin
          case (bus.cmd_data)
            CMD_RESET: begin state_d = S_PRST; prst_cmd_d = 1'b1; end
            CMD_STEP, CMD_CONT: begin
              state_d = S_REPORT; status_d = ST_HALTED; ret_d = S_DONE;
            end
            default: begin state_d = S_REPORT; status_d = ST_BADCMD; ret_d = S_DONE; end
          endcase
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enabled-cycle counter: saturating, cleared during PRST
  always_comb begin
    count_d = count_q;
    if (state_q == S_PRST) begin
      count_d = {CYCLE_W{1'b0}};
    end else if (enable_s && (count_q != {CYCLE_W{1'b1}})) begin
      count_d = count_q + CYCLE_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_PRST;
      ret_q      <= S_IDLE;
      status_q   <= 8'h00;
      prst_cmd_q <= 1'b0;
      drain_q    <= {DRAIN_W{1'b0}};
      count_q    <= {CYCLE_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      status_q   <= status_d;
      prst_cmd_q <= prst_cmd_d;
      drain_q    <= drain_d;
      count_q    <= count_d;
    end
  end

  assign bus.cmd_ready     = ready_s;
  assign bus.pc_enable_out = enable_s;
  assign bus.pc_reset_out  = (state_q == S_PRST);
  assign bus.cycle_count   = count_q;
  assign bus.status_data   = status_q;
  assign bus.status_valid  = (state_q == S_REPORT);
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Self-checking bench for pipeline_exec_ctrl: directed command table, randomized
// command stream against a transaction-level model, and reset corner sequences.
module tb_pipeline_exec_ctrl;

  localparam logic [5:0] HALT = 6'h3F;
  localparam int         D    = 4;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DONE = 3'd6;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   fails   = 0;

  pipeline_exec_ctrl_if #(.CYCLE_W(32)) bus ();

  pipeline_exec_ctrl #(.CYCLE_W(32), .HALT_OPCODE(6'b111111), .DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    int         k;
    bit         halt;
    bit         pause;
    int         rdly;
    logic [7:0] st;
    int         cnt;
    int         en;
    logic [2:0] state;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    op = 6'($urandom_range(0, 62));
    return {op, 26'($urandom)};
  endfunction

  // Issue one command, drive HALT/pause at the k-th enabled cycle, then collect the status byte.
  task automatic exec(input vec_t v);
    int  en;
    int  t;
    bit  got;
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_data  = v.cmd;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    en  = 0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      bus.pc_instr_in = rnd_instr();
      bus.cmd_valid   = 1'b0;
      if (bus.status_valid) begin
        got = 1'b1;
      end else begin
        if (bus.pc_enable_out) begin
          en++;
          if (en == v.k) begin
            if (v.halt) bus.pc_instr_in = {HALT, 26'($urandom)};
            if (v.pause) begin
              bus.cmd_data  = 8'h50;
              bus.cmd_valid = 1'b1;
            end
          end else if (v.cmd == 8'h43 && en < v.k && $urandom_range(0, 3) == 0) begin
            bus.cmd_data  = 8'h41;
            bus.cmd_valid = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    chk("status_seen", got, 1);
    chk("status_data", bus.status_data, v.st);
    chk("cycle_count", bus.cycle_count, v.cnt);
    chk("enabled_cycles", en, v.en);
    for (int d = 0; d < v.rdly; d++) begin
      @(negedge clk);
      chk("status_hold_data", bus.status_data, v.st);
      chk("status_hold_valid", bus.status_valid, 1);
      chk("status_hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.status_ready = 1'b1;
    @(negedge clk);
    bus.status_ready = 1'b0;
    chk("state_after_report", bus.state_out, v.state);
    chk("status_valid_cleared", bus.status_valid, 0);
  endtask

  initial begin
    vec_t v;
    int   cnt;
    bit   halted;
    int   en;

    reset            = 1'b1;
    bus.cmd_data     = 8'h00;
    bus.cmd_valid    = 1'b0;
    bus.status_ready = 1'b0;
    bus.pc_instr_in  = 32'h0000_0000;

    tbl.push_back('{8'h53, 1,  1'b0, 1'b0, 0, 8'h01, 1,  1,  IDLE});
    tbl.push_back('{8'h53, 1,  1'b0, 1'b0, 1, 8'h01, 2,  1,  IDLE});
    tbl.push_back('{8'h53, 1,  1'b0, 1'b0, 0, 8'h01, 3,  1,  IDLE});
    tbl.push_back('{8'h52, 0,  1'b0, 1'b0, 0, 8'h00, 0,  0,  IDLE});
    tbl.push_back('{8'h43, 10, 1'b1, 1'b0, 2, 8'h02, 14, 14, DONE});
    tbl.push_back('{8'h43, 0,  1'b0, 1'b0, 0, 8'hE1, 14, 0,  DONE});
    tbl.push_back('{8'h53, 0,  1'b0, 1'b0, 0, 8'hE1, 14, 0,  DONE});
    tbl.push_back('{8'h50, 0,  1'b0, 1'b0, 0, 8'hEE, 14, 0,  DONE});
    tbl.push_back('{8'h41, 0,  1'b0, 1'b0, 0, 8'hEE, 14, 0,  DONE});
    tbl.push_back('{8'h52, 0,  1'b0, 1'b0, 0, 8'h00, 0,  0,  IDLE});
    tbl.push_back('{8'h43, 6,  1'b0, 1'b1, 5, 8'h03, 6,  6,  IDLE});
    tbl.push_back('{8'h43, 3,  1'b1, 1'b1, 0, 8'h02, 13, 7,  DONE});
    tbl.push_back('{8'h52, 0,  1'b0, 1'b0, 0, 8'h00, 0,  0,  IDLE});
    tbl.push_back('{8'h41, 0,  1'b0, 1'b0, 0, 8'hEE, 0,  0,  IDLE});
    tbl.push_back('{8'h50, 0,  1'b0, 1'b0, 0, 8'hEE, 0,  0,  IDLE});
    tbl.push_back('{8'h53, 1,  1'b1, 1'b0, 0, 8'h02, 5,  5,  DONE});
    tbl.push_back('{8'h52, 0,  1'b0, 1'b0, 0, 8'h00, 0,  0,  IDLE});

    // Power-on reset held for two edges
    @(negedge clk);
    chk("rst_state", bus.state_out, 3'd1);
    chk("rst_pc_reset", bus.pc_reset_out, 1);
    chk("rst_pc_enable", bus.pc_enable_out, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_status_valid", bus.status_valid, 0);
    chk("rst_status_data", bus.status_data, 8'h00);
    chk("rst_cycle_count", bus.cycle_count, 0);
    @(negedge clk);
    chk("rst_pc_reset_held", bus.pc_reset_out, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", bus.state_out, IDLE);
    chk("post_rst_pc_reset", bus.pc_reset_out, 0);
    chk("post_rst_status_valid", bus.status_valid, 0);
    chk("post_rst_cycle_count", bus.cycle_count, 0);

    foreach (tbl[i]) exec(tbl[i]);

    // Randomized commands against a transaction-level model
    cnt    = 0;
    halted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       v.cmd = 8'h52;
        1, 2:    v.cmd = 8'h53;
        3:       v.cmd = 8'h43;
        4:       v.cmd = 8'h50;
        default: v.cmd = 8'($urandom_range(0, 255));
      endcase
      v.halt  = ($urandom_range(0, 2) == 0);
      v.pause = 1'b0;
      v.k     = 0;
      v.rdly  = $urandom_range(0, 3);
      en      = 0;
      if (v.cmd == 8'h52) begin
        v.st = 8'h00; cnt = 0; halted = 1'b0;
      end else if (halted) begin
        v.st = (v.cmd == 8'h53 || v.cmd == 8'h43) ? 8'hE1 : 8'hEE;
      end else if (v.cmd == 8'h53) begin
        v.k  = 1;
        en   = v.halt ? 1 + D : 1;
        v.st = v.halt ? 8'h02 : 8'h01;
        halted = v.halt;
      end else if (v.cmd == 8'h43) begin
        v.k     = $urandom_range(1, 12);
        v.pause = v.halt ? bit'($urandom_range(0, 1)) : 1'b1;
        en      = v.halt ? v.k + D : v.k;
        v.st    = v.halt ? 8'h02 : 8'h03;
        halted  = v.halt;
      end else begin
        v.st = 8'hEE;
      end
      cnt     = cnt + en;
      v.cnt   = cnt;
      v.en    = en;
      v.state = halted ? DONE : IDLE;
      exec(v);
    end

    // Reset landing in the second DRAIN cycle
    v = '{8'h52, 0, 1'b0, 1'b0, 0, 8'h00, 0, 0, IDLE};
    exec(v);
    bus.cmd_data  = 8'h43;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    en = 0;
    for (int t = 0; t < 50 && en < 2; t++) begin
      bus.pc_instr_in = rnd_instr();
      if (bus.pc_enable_out) en++;
      if (en == 2) bus.pc_instr_in = {HALT, 26'h0};
      @(negedge clk);
    end
    bus.pc_instr_in = rnd_instr();
    chk("drain1_state", bus.state_out, 3'd4);
    @(negedge clk);
    chk("drain2_state", bus.state_out, 3'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("drain_rst_state", bus.state_out, 3'd1);
    chk("drain_rst_status_valid", bus.status_valid, 0);
    chk("drain_rst_cycle_count", bus.cycle_count, 0);
    chk("drain_rst_pc_enable", bus.pc_enable_out, 0);
    chk("drain_rst_pc_reset", bus.pc_reset_out, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("drain_rst_idle", bus.state_out, IDLE);
    chk("drain_rst_no_status", bus.status_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_ctrl.md
# pipeline_exec_ctrl

Execution controller that sequences the MIPS pipeline through its `pc_enable_in`/`pc_reset` controls. It accepts byte commands from a debug host (UART receiver side) to reset, single-step or free-run the pipeline, detects the HALT instruction at fetch and drains the pipeline, counts enabled cycles, and returns one status byte per command over a valid/ready channel.

## Interface
- `CYCLE_W`, 32, width of the enabled-cycle counter
- `HALT_OPCODE`, 6'b111111, opcode field (`instr[31:26]`) identifying HALT
- `DRAIN_CYCLES`, 4, enabled cycles issued after HALT is fetched (must be ≥1)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_data`  in  8  command byte
- `cmd_valid`  in  1  command byte present
- `cmd_ready`  out  1  controller accepts `cmd_data` this cycle
- `pc_instr_in`  in  32  instruction at fetch (pipeline `pc_instr_out`)
- `pc_enable_out`  out  1  drives pipeline `pc_enable_in`
- `pc_reset_out`  out  1  drives pipeline `pc_reset`
- `cycle_count`  out  CYCLE_W  number of cycles with `pc_enable_out`=1
- `status_data`  out  8  status byte
- `status_valid`  out  1  status byte present
- `status_ready`  in  1  host consumed status
- `state_out`  out  3  current state encoding (debug)

## Operation
- States: IDLE=0, PRST=1, STEP=2, RUN=3, DRAIN=4, REPORT=5, DONE=6. Outputs are Moore functions of state plus registered status/counter.
- Commands (accepted when `cmd_valid && cmd_ready`): 0x52 'R' reset, 0x53 'S' step, 0x43 'C' continue, 0x50 'P' pause.
- `cmd_ready`=1 only in IDLE, RUN, DONE.
- IDLE: 'R'→PRST; 'S'→STEP; 'C'→RUN; 'P' or unknown→REPORT with 0xEE.
- PRST: `pc_reset_out`=1 for exactly one cycle, `cycle_count` cleared; if entered by 'R' → REPORT 0x00, if entered by `reset` → IDLE (no status).
- STEP: `pc_enable_out`=1 one cycle; if HALT at fetch that cycle → DRAIN, else REPORT 0x01.
- RUN: `pc_enable_out`=1 every cycle; HALT at fetch → DRAIN; 'P' accepted → REPORT 0x03 (last enabled cycle is the acceptance cycle); other bytes accepted and silently discarded.
- HALT detect: `pc_instr_in[31:26]==HALT_OPCODE` in a cycle with `pc_enable_out`=1. HALT and 'P' in the same cycle: HALT wins, 'P' discarded.
- DRAIN: `pc_enable_out`=1 for exactly DRAIN_CYCLES cycles (down-counter), then REPORT 0x02; HALT detection disabled.
- REPORT: `status_valid`=1, `status_data` stable until `status_ready`=1; then → DONE if status was 0x02, else IDLE. Status 0xE1 and 0xEE return to the state they were issued from.
- DONE: 'R'→PRST; 'S','C'→REPORT 0xE1; 'P'/unknown→REPORT 0xEE. Pipeline never enabled from DONE.
- `cycle_count` increments in every cycle `pc_enable_out`=1, saturates at all-ones, cleared only by `reset` or PRST.

## Timing
- `reset` asserted: next edge state=PRST, `cycle_count`=0, `status_valid`=0, `status_data`=0x00, `pc_enable_out`=0, `cmd_ready`=0; `pc_reset_out`=1 while `reset` high and for the PRST cycle after deassertion. Reset mid-RUN/DRAIN/REPORT aborts immediately, pending status discarded.
- Command accepted at edge N → new state visible cycle N+1; STEP `pc_enable_out` high in cycle N+1 only; `status_valid` rises cycle N+2 (no HALT).
- 'C' at N: enable high from N+1; HALT fetched in cycle M → enable high through M+DRAIN_CYCLES, `status_valid`=1 from M+DRAIN_CYCLES+1.
- REPORT exits on the edge where `status_ready`=1; `cmd_ready` may be 1 the following cycle.
- No combinational path from `cmd_*` or `status_ready` to any output.

## Test plan
- `reset` 2 cycles → `pc_reset_out`=1 through PRST, then IDLE, `cycle_count`=0, no status byte.
- 'S' ×3 with non-HALT instructions, `status_ready`=1 → three 0x01 bytes, `pc_enable_out` pulsed 1 cycle each, `cycle_count`=3.
- 'C', HALT presented at 10th enabled cycle, DRAIN_CYCLES=4 → status 0x02, `cycle_count`=14, then 'C' → 0xE1, 'R' → 0x00 and `cycle_count`=0.
- 'C' then 'P' at 6th enabled cycle with `status_ready`=0 for 5 cycles → `status_data`=0x03 held stable, `cmd_ready`=0 throughout, `cycle_count`=6.
- 'P' and HALT in same RUN cycle → DRAIN entered, single status 0x02, no 0x03; unknown byte 0x41 in IDLE → 0xEE, state returns IDLE.
- `reset` asserted in the 2nd DRAIN cycle → state PRST next cycle, `status_valid`=0, `cycle_count`=0.
